// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and constants for key event decoding
//
// Purpose:
//   Holds the FSM state type, the default 100 MHz timing constants and the
//   key polarity constant. Every key block imports this package.
//
// Contents:
//   key_state_t          IDLE / HELD / LONG
//   LONG_CNT_DEFAULT     hold cycles minus 1 before long press (2 s)
//   REPEAT_CNT_DEFAULT   cycles minus 1 between repeats (200 ms)
//   CNT_W_DEFAULT        counter width covering both constants
//   KEY_PRESSED          level of the key input when pressed

package key_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } key_state_t;

  localparam int LONG_CNT_DEFAULT   = 199_999_999;
  localparam int REPEAT_CNT_DEFAULT = 19_999_999;
  localparam int CNT_W_DEFAULT      = 28;

  localparam logic KEY_PRESSED = 1'b0;

endpackage

// File: rtl/key_edge_det.sv
// rtl/key_edge_det.sv - single input register with fall/rise detection
//
// Purpose:
//   Registers an already debounced key level once and reports its edges.
//   The register resets to "released" so that a key held down across reset
//   release is seen as a fresh press on the first clock.
//
// Ports:
//   i_clk        system clock
//   i_rst        synchronous, active-high reset
//   i_key_level  debounced key level, 0 = pressed
//   o_fall       combinational: level went from released to pressed
//   o_rise       combinational: level went from pressed to released

module key_edge_det
  import key_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_level,
  output logic o_fall,
  output logic o_rise
);

  logic r_key_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_key_d <= ~KEY_PRESSED;
    end else begin
      r_key_d <= i_key_level;
    end
  end

  assign o_fall = ~i_key_level &  r_key_d;
  assign o_rise =  i_key_level & ~r_key_d;

endmodule

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - turns a debounced key level into event pulses
//
// Purpose:
//   Generates one-cycle press, release, short click, long press and
//   auto-repeat pulses from a debounced active-low key, plus a held level.
//   All outputs are registered.
//
// Configuration:
//   KEY_REPEAT_EN  defined: repeat_pulse fires every REPEAT_CNT+1 cycles
//                  while long-held. Undefined: repeat_pulse is tied to 0
//                  and the counter idles at 0 in LONG.
//
// Ports:
//   i_clk            system clock, 100 MHz
//   i_rst            synchronous, active-high reset
//   i_key_level      debounced key level, 0 = pressed, 1 = released
//   o_press_pulse    one-cycle pulse on press
//   o_release_pulse  one-cycle pulse on release
//   o_short_click    one-cycle pulse on release before the long threshold
//   o_long_press     one-cycle pulse when the hold reaches the threshold
//   o_repeat_pulse   one-cycle pulse periodically during a long hold
//   o_key_held       level, 1 while the FSM is not IDLE

module key_event_decoder
  import key_pkg::*;
#(
  parameter int LONG_CNT   = LONG_CNT_DEFAULT,
  parameter int REPEAT_CNT = REPEAT_CNT_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_level,
  output logic o_press_pulse,
  output logic o_release_pulse,
  output logic o_short_click,
  output logic o_long_press,
  output logic o_repeat_pulse,
  output logic o_key_held
);

  // The counter is cleared at its threshold, so it only has to reach the
  // larger of the two compare values.
  localparam int MAX_CNT = (LONG_CNT > REPEAT_CNT) ? LONG_CNT : REPEAT_CNT;

  generate
    if ((MAX_CNT >> CNT_W) != 0) begin : g_cnt_w_check
      $error("key_event_decoder: CNT_W too small for LONG_CNT/REPEAT_CNT");
    end
  endgenerate

  logic             w_fall;
  logic             w_rise;
  logic             w_long_hit;
  key_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press_pulse;
  logic             r_release_pulse;
  logic             r_short_click;
  logic             r_long_press;
  logic             r_key_held;

  key_edge_det u_edge (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_key_level (i_key_level),
    .o_fall      (w_fall),
    .o_rise      (w_rise)
  );

  assign w_long_hit = (r_cnt == CNT_W'(LONG_CNT));

`ifdef KEY_REPEAT_EN
  logic w_repeat_hit;
  logic r_repeat_pulse;

  assign w_repeat_hit = (r_cnt == CNT_W'(REPEAT_CNT));
`endif

  // In HELD and LONG the registered level is always "pressed" (the state is
  // left as soon as a released level is seen), so w_rise is exactly the
  // condition "key_level is released" in those states.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_short_click   <= 1'b0;
      r_long_press    <= 1'b0;
      r_key_held      <= 1'b0;
`ifdef KEY_REPEAT_EN
      r_repeat_pulse  <= 1'b0;
`endif
    end else begin
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_short_click   <= 1'b0;
      r_long_press    <= 1'b0;
`ifdef KEY_REPEAT_EN
      r_repeat_pulse  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state       <= HELD;
            r_cnt         <= '0;
            r_press_pulse <= 1'b1;
            r_key_held    <= 1'b1;
          end
        end
        HELD: begin
          // Release takes priority over reaching the long threshold.
          if (w_rise) begin
            r_state         <= IDLE;
            r_release_pulse <= 1'b1;
            r_short_click   <= 1'b1;
            r_key_held      <= 1'b0;
          end else if (w_long_hit) begin
            r_state      <= LONG;
            r_cnt        <= '0;
            r_long_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        LONG: begin
          if (w_rise) begin
            r_state         <= IDLE;
            r_release_pulse <= 1'b1;
            r_key_held      <= 1'b0;
          end else begin
`ifdef KEY_REPEAT_EN
            if (w_repeat_hit) begin
              r_cnt          <= '0;
              r_repeat_pulse <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
`else
            r_cnt <= '0;
`endif
          end
        end
        default: begin
          r_state    <= IDLE;
          r_key_held <= 1'b0;
        end
      endcase
    end
  end

  assign o_press_pulse   = r_press_pulse;
  assign o_release_pulse = r_release_pulse;
  assign o_short_click   = r_short_click;
  assign o_long_press    = r_long_press;
  assign o_key_held      = r_key_held;
`ifdef KEY_REPEAT_EN
  assign o_repeat_pulse  = r_repeat_pulse;
`else
  assign o_repeat_pulse  = 1'b0;
`endif

endmodule
